// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared types and defaults for the CNN layer sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int c_default_bit_width = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        SWAP   = 3'd3,
        FINISH = 3'd4
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/bank_mux.sv
`default_nettype none
// ============================================================================
//  Module      : bank_mux
//  Description : Combinational routing of host/engine ports onto two RAM banks.
//  Revision    : 1.0 - initial release
// ============================================================================
module bank_mux #(
    parameter int AW        = 4,
    parameter int BIT_WIDTH = 16
) (
    input  logic                 bank_sel,
    input  logic                 idle,
    input  logic                 wr_block,
    input  logic [AW-1:0]        conv_addr_rd,
    output logic [BIT_WIDTH-1:0] conv_data_rd,
    input  logic [AW-1:0]        conv_addr_wr,
    input  logic [BIT_WIDTH-1:0] conv_data_wr,
    input  logic                 conv_wren,
    input  logic [AW-1:0]        host_addr,
    input  logic [BIT_WIDTH-1:0] host_data,
    input  logic                 host_wren,
    output logic [BIT_WIDTH-1:0] host_q,
    output logic [AW-1:0]        ram0_addr,
    output logic [BIT_WIDTH-1:0] ram0_data,
    output logic                 ram0_wren,
    input  logic [BIT_WIDTH-1:0] ram0_q,
    output logic [AW-1:0]        ram1_addr,
    output logic [BIT_WIDTH-1:0] ram1_data,
    output logic                 ram1_wren,
    input  logic [BIT_WIDTH-1:0] ram1_q
);

    // "in" side is bank bank_sel (host when idle, engine read otherwise);
    // "out" side is the other bank, only writable by the engine during a run.
    logic [AW-1:0]        w_in_addr;
    logic [BIT_WIDTH-1:0] w_in_data;
    logic                 w_in_wren;
    logic                 w_out_wren;
    logic [BIT_WIDTH-1:0] w_sel_q;

    assign w_in_addr  = idle ? host_addr : conv_addr_rd;
    assign w_in_data  = idle ? host_data : '0;
    assign w_in_wren  = idle & host_wren & ~wr_block;
    assign w_out_wren = ~idle & conv_wren & ~wr_block;

    assign ram0_addr = bank_sel ? conv_addr_wr : w_in_addr;
    assign ram0_data = bank_sel ? conv_data_wr : w_in_data;
    assign ram0_wren = bank_sel ? w_out_wren   : w_in_wren;
    assign ram1_addr = bank_sel ? w_in_addr    : conv_addr_wr;
    assign ram1_data = bank_sel ? w_in_data    : conv_data_wr;
    assign ram1_wren = bank_sel ? w_in_wren    : w_out_wren;

    assign w_sel_q      = bank_sel ? ram1_q : ram0_q;
    assign conv_data_rd = w_sel_q;
    assign host_q       = idle ? w_sel_q : '0;

endmodule
`default_nettype wire

// File: rtl/cnn_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_layer_sequencer
//  Description : Runs NUM_LAYERS convolution passes over ping-pong RAM banks.
//  Revision    : 1.0 - initial release
// ============================================================================
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int  NUM_LAYERS = 4,
    parameter int  BIT_WIDTH  = c_default_bit_width,
    parameter int  RAM_DEPTH  = 16,
    localparam int AW         = $clog2(RAM_DEPTH),
    localparam int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [LW-1:0]        layer_idx,
    output logic                 bank_sel,
    output logic                 conv_start,
    input  logic                 conv_done,
    input  logic [AW-1:0]        conv_addr_rd,
    output logic [BIT_WIDTH-1:0] conv_data_rd,
    input  logic [AW-1:0]        conv_addr_wr,
    input  logic [BIT_WIDTH-1:0] conv_data_wr,
    input  logic                 conv_wren,
    input  logic [AW-1:0]        host_addr,
    input  logic [BIT_WIDTH-1:0] host_data,
    input  logic                 host_wren,
    output logic [BIT_WIDTH-1:0] host_q,
    output logic [AW-1:0]        ram0_addr,
    output logic [BIT_WIDTH-1:0] ram0_data,
    output logic                 ram0_wren,
    input  logic [BIT_WIDTH-1:0] ram0_q,
    output logic [AW-1:0]        ram1_addr,
    output logic [BIT_WIDTH-1:0] ram1_data,
    output logic                 ram1_wren,
    input  logic [BIT_WIDTH-1:0] ram1_q
);

    localparam logic [LW-1:0] c_last_layer = LW'(NUM_LAYERS - 1);

    seq_state_t    r_state;
    logic          r_bank_sel;
    logic [LW-1:0] r_layer_idx;
    logic          r_conv_start;
    logic          r_done;
    logic          r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bank_sel   <= 1'b0;
            r_layer_idx  <= '0;
            r_conv_start <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_conv_start <= 1'b0;
            r_done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_layer_idx <= '0;
                    if (start) begin
                        r_state      <= LAUNCH;
                        r_conv_start <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                LAUNCH: r_state <= RUN;
                RUN: begin
                    if (conv_done) begin
                        r_state <= SWAP;
                    end
                end
                SWAP: begin
                    // The bank just written becomes the next layer's input.
                    r_bank_sel <= ~r_bank_sel;
                    if (r_layer_idx == c_last_layer) begin
                        r_state <= FINISH;
                        r_done  <= 1'b1;
                    end else begin
                        r_layer_idx  <= r_layer_idx + LW'(1);
                        r_state      <= LAUNCH;
                        r_conv_start <= 1'b1;
                    end
                end
                FINISH: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_layer_idx <= '0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign layer_idx  = r_layer_idx;
    assign bank_sel   = r_bank_sel;
    assign conv_start = r_conv_start;

    bank_mux #(
        .AW        (AW),
        .BIT_WIDTH (BIT_WIDTH)
    ) u_bank_mux (
        .bank_sel     (r_bank_sel),
        .idle         (r_state == IDLE),
        .wr_block     (rst),
        .conv_addr_rd (conv_addr_rd),
        .conv_data_rd (conv_data_rd),
        .conv_addr_wr (conv_addr_wr),
        .conv_data_wr (conv_data_wr),
        .conv_wren    (conv_wren),
        .host_addr    (host_addr),
        .host_data    (host_data),
        .host_wren    (host_wren),
        .host_q       (host_q),
        .ram0_addr    (ram0_addr),
        .ram0_data    (ram0_data),
        .ram0_wren    (ram0_wren),
        .ram0_q       (ram0_q),
        .ram1_addr    (ram1_addr),
        .ram1_data    (ram1_data),
        .ram1_wren    (ram1_wren),
        .ram1_q       (ram1_q)
    );

endmodule
`default_nettype wire

// File: tb/tb_cnn_layer_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_cnn_layer_sequencer
//  Description : Self-checking bench with RAM and convolution engine models.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cnn_layer_sequencer;

    localparam int NL    = 4;
    localparam int BW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int LW    = 2;

    logic          clk = 1'b0;
    logic          rst, start, busy, done, bank_sel, conv_start, conv_done;
    logic [LW-1:0] layer_idx;
    logic [AW-1:0] conv_addr_rd, conv_addr_wr, host_addr, ram0_addr, ram1_addr;
    logic [BW-1:0] conv_data_rd, conv_data_wr, host_data, host_q;
    logic [BW-1:0] ram0_data, ram1_data, ram0_q, ram1_q;
    logic          conv_wren, host_wren, ram0_wren, ram1_wren;

    logic [BW-1:0] mem0 [DEPTH];
    logic [BW-1:0] mem1 [DEPTH];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Logs written only by the monitor / engine processes
    int            n_starts = 0;
    logic [LW-1:0] st_layer [64];
    logic          st_bank  [64];
    int            st_cyc   [64];
    int            n_cd = 0;
    int            cd_cyc   [64];

    bit            eng_data = 1'b0;
    bit            eng_spur = 1'b0;
    int            done_cyc = 0;
    logic [BW-1:0] model [DEPTH];

    always #5 clk = ~clk;

    cnn_layer_sequencer #(
        .NUM_LAYERS (NL),
        .BIT_WIDTH  (BW),
        .RAM_DEPTH  (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .layer_idx    (layer_idx),
        .bank_sel     (bank_sel),
        .conv_start   (conv_start),
        .conv_done    (conv_done),
        .conv_addr_rd (conv_addr_rd),
        .conv_data_rd (conv_data_rd),
        .conv_addr_wr (conv_addr_wr),
        .conv_data_wr (conv_data_wr),
        .conv_wren    (conv_wren),
        .host_addr    (host_addr),
        .host_data    (host_data),
        .host_wren    (host_wren),
        .host_q       (host_q),
        .ram0_addr    (ram0_addr),
        .ram0_data    (ram0_data),
        .ram0_wren    (ram0_wren),
        .ram0_q       (ram0_q),
        .ram1_addr    (ram1_addr),
        .ram1_data    (ram1_data),
        .ram1_wren    (ram1_wren),
        .ram1_q       (ram1_q)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram0_wren) mem0[ram0_addr] <= ram0_data;
        if (ram1_wren) mem1[ram1_addr] <= ram1_data;
        ram0_q <= mem0[ram0_addr];
        ram1_q <= mem1[ram1_addr];
    end

    always @(negedge clk) begin
        if (conv_start === 1'b1 && n_starts < 64) begin
            st_layer[n_starts] = layer_idx;
            st_bank[n_starts]  = bank_sel;
            st_cyc[n_starts]   = cyc;
            n_starts++;
        end
    end

    // Engine: in data mode it streams the input bank, writes in+layer+1 to the
    // output bank, then pulses conv_done after a random latency.
    initial begin : engine
        logic [LW-1:0] lay;
        int            lat;
        conv_done = 1'b0; conv_wren = 1'b0;
        conv_addr_rd = '0; conv_addr_wr = '0; conv_data_wr = '0;
        forever begin
            @(negedge clk);
            if (conv_start === 1'b1 && rst !== 1'b1) begin
                lay = layer_idx;
                lat = eng_data ? int'($urandom_range(24, 17)) : 5;
                if (eng_spur) conv_done = 1'b1;
                for (int k = 0; k < lat; k++) begin
                    conv_wren = 1'b0;
                    if (eng_data) begin
                        if (k < DEPTH) conv_addr_rd = AW'(k);
                        if (k >= 1 && k <= DEPTH) begin
                            conv_addr_wr = AW'(k - 1);
                            conv_data_wr = conv_data_rd + BW'(lay) + 16'd1;
                            conv_wren    = 1'b1;
                        end
                    end
                    @(negedge clk);
                    #2;
                    conv_done = 1'b0;
                    if (rst === 1'b1) break;
                end
                conv_wren = 1'b0;
                if (rst !== 1'b1) begin
                    conv_done = 1'b1;
                    if (n_cd < 64) cd_cyc[n_cd] = cyc;
                    n_cd++;
                    @(negedge clk);
                    conv_done = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [BW-1:0] d);
        @(negedge clk);
        host_addr = a; host_data = d; host_wren = 1'b1;
        @(negedge clk);
        host_wren = 1'b0;
    endtask

    task automatic host_read(input logic [AW-1:0] a, input logic [BW-1:0] exp, input string name);
        @(negedge clk);
        host_addr = a; host_wren = 1'b0;
        @(negedge clk);
        chk(name, host_q, exp);
    endtask

    task automatic start_run(input bit hw, input logic [AW-1:0] a, input logic [BW-1:0] d);
        @(negedge clk);
        start = 1'b1; host_wren = hw; host_addr = a; host_data = d;
        #1;
        if (hw) chk("start_host_wr", {ram1_wren, ram0_wren}, 2'b01);
        @(negedge clk);
        start = 1'b0; host_wren = 1'b0;
        chk("busy_T+1", busy, 1'b1);
        chk("conv_start_T+1", conv_start, 1'b1);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin seen = 1'b1; break; end
        end
        chk({tag, "_done_seen"}, 32'(seen), 1);
        done_cyc = cyc;
        if (seen) begin
            @(negedge clk);
            chk({tag, "_busy_after"}, busy, 1'b0);
            chk({tag, "_done_pulse"}, done, 1'b0);
        end
    endtask

    task automatic check_run(input int bs, input int bd, input logic b0, input string tag);
        chk({tag, "_n_starts"}, n_starts - bs, NL);
        for (int i = 0; i < NL; i++) begin
            if (bs + i < n_starts) begin
                chk({tag, "_layer"}, 32'(st_layer[bs + i]), i);
                chk({tag, "_bank"}, st_bank[bs + i], b0 ^ 1'(i & 1));
                if (i > 0 && bd + i - 1 < n_cd)
                    chk({tag, "_gap"}, st_cyc[bs + i] - cd_cyc[bd + i - 1], 2);
            end
        end
        if (bd + NL - 1 < n_cd) chk({tag, "_done_lat"}, done_cyc - cd_cyc[bd + NL - 1], 2);
        else chk({tag, "_n_cd"}, n_cd - bd, NL);
        chk({tag, "_final_bank"}, bank_sel, b0 ^ 1'(NL & 1));
    endtask

    task automatic load_random();
        logic [BW-1:0] v;
        for (int a = 0; a < DEPTH; a++) begin
            v = BW'($urandom);
            host_write(AW'(a), v);
            model[a] = v;
        end
    endtask

    // Every layer adds (layer+1) to each word; the result lands in the
    // bank the host reads once the run is over.
    task automatic verify_results(input string tag);
        logic [BW-1:0] e;
        for (int a = 0; a < DEPTH; a++) begin
            e = model[a];
            for (int l = 0; l < NL; l++) e = e + BW'(l + 1);
            host_read(AW'(a), e, {tag, "_result"});
        end
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] data;
        logic          chk_q;
        logic [BW-1:0] exp_q;
        logic          exp_w0;
    } vec_t;

    initial begin : main
        vec_t tbl [2*DEPTH];
        int   bs, bd;
        bit   seen;

        for (int i = 0; i < DEPTH; i++) begin
            tbl[i]         = '{1'b1, AW'(i), BW'(i + 1), 1'b0, '0, 1'b1};
            tbl[DEPTH + i] = '{1'b0, AW'(i), '0, 1'b1, BW'(i + 1), 1'b0};
        end

        rst = 1'b1; start = 1'b0;
        host_wren = 1'b1; host_addr = 4'd3; host_data = 16'hDEAD;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_conv_start", conv_start, 1'b0);
        chk("rst_layer", 32'(layer_idx), 0);
        chk("rst_bank", bank_sel, 1'b0);
        chk("rst_wren", {ram1_wren, ram0_wren}, 2'b00);
        rst = 1'b0; host_wren = 1'b0;

        // Host write then read-back through the idle routing
        for (int i = 0; i < 2 * DEPTH; i++) begin
            @(negedge clk);
            if (i > 0 && tbl[i-1].chk_q) chk("tbl_host_q", host_q, tbl[i-1].exp_q);
            host_wren = tbl[i].wr; host_addr = tbl[i].addr; host_data = tbl[i].data;
            #1;
            chk("tbl_ram0_wren", ram0_wren, tbl[i].exp_w0);
            chk("tbl_ram1_wren", ram1_wren, 1'b0);
        end
        @(negedge clk);
        chk("tbl_host_q", host_q, tbl[2*DEPTH-1].exp_q);
        host_wren = 1'b0;

        // Run A: fixed 5-cycle engine, host write coincident with start
        eng_data = 1'b0; eng_spur = 1'b0;
        bs = n_starts; bd = n_cd;
        start_run(1'b1, 4'd5, 16'hBEEF);
        wait_done("runA");
        check_run(bs, bd, 1'b0, "runA");
        host_read(4'd5, 16'hBEEF, "runA_hostwr");
        host_read(4'd6, 16'h0007, "runA_keep");

        // Run B: random data; first pass also injects spurious controls
        for (int r = 0; r < 2; r++) begin
            eng_data = 1'b1; eng_spur = (r == 0);
            load_random();
            bs = n_starts; bd = n_cd;
            start_run(1'b0, '0, '0);
            if (r == 0) begin
                seen = 1'b0;
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk);
                    if (conv_start === 1'b1 && layer_idx == 2'd1) begin seen = 1'b1; break; end
                end
                chk("runB_l1_seen", 32'(seen), 1);
                @(negedge clk);
                start = 1'b1; host_wren = 1'b1;
                host_addr = AW'($urandom); host_data = BW'($urandom);
                #1;
                chk("busy_host_q", host_q, '0);
                chk("busy_host_wren", {ram1_wren, ram0_wren},
                    conv_wren ? (bank_sel ? 2'b01 : 2'b10) : 2'b00);
                @(negedge clk);
                start = 1'b0; host_wren = 1'b0;
            end
            wait_done("runB");
            check_run(bs, bd, 1'b0, "runB");
            verify_results("runB");
        end

        // Run C: reset asserted during layer 2, then a clean run
        eng_data = 1'b1; eng_spur = 1'b0;
        load_random();
        start_run(1'b0, '0, '0);
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (conv_start === 1'b1 && layer_idx == 2'd2) begin seen = 1'b1; break; end
        end
        chk("runC_l2_seen", 32'(seen), 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_wren", {ram1_wren, ram0_wren}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_bank", bank_sel, 1'b0);
        chk("abort_layer", 32'(layer_idx), 0);
        chk("abort_conv_start", conv_start, 1'b0);
        repeat (3) @(negedge clk);

        load_random();
        bs = n_starts; bd = n_cd;
        start_run(1'b0, '0, '0);
        wait_done("runD");
        check_run(bs, bd, 1'b0, "runD");
        verify_results("runD");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/cnn_layer_sequencer.md
# cnn_layer_sequencer

Sequences a chain of `NUM_LAYERS` convolution passes over two ping-pong sample RAM banks and arbitrates bank access between the host and the convolution engine. Each layer pulses the engine's `start`, waits for its `done`, then swaps banks so that layer N's output becomes layer N+1's input. The block sits between the top-level host/loader logic, the single convolution engine and two external single-port RAMs.

## Interface
- `NUM_LAYERS`, 4: number of convolution passes per run, ≥1.
- `BIT_WIDTH`, 16: sample width.
- `RAM_DEPTH`, 16: words per bank; `AW = $clog2(RAM_DEPTH)`.

- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: run request, sampled in IDLE only.
- `busy` out 1: high from the cycle after an accepted `start` through the DONE state.
- `done` out 1: one-cycle pulse at run completion.
- `layer_idx` out `$clog2(NUM_LAYERS)` (min 1): current layer, selects engine kernel set.
- `bank_sel` out 1: current input bank.
- `conv_start` out 1: one-cycle start pulse to the engine.
- `conv_done` in 1: engine completion pulse.
- `conv_addr_rd` in AW, `conv_data_rd` out BIT_WIDTH: engine read port.
- `conv_addr_wr` in AW, `conv_data_wr` in BIT_WIDTH, `conv_wren` in 1: engine write port.
- `host_addr` in AW, `host_data` in BIT_WIDTH, `host_wren` in 1, `host_q` out BIT_WIDTH: host port.
- `ram0_addr`/`ram1_addr` out AW, `ram0_data`/`ram1_data` out BIT_WIDTH, `ram0_wren`/`ram1_wren` out 1, `ram0_q`/`ram1_q` in BIT_WIDTH: bank ports.

## Operation
- States: IDLE, LAUNCH, RUN, SWAP, FINISH.
- IDLE: `start`=1 → LAUNCH. `layer_idx`=0. `bank_sel` is unchanged.
- LAUNCH: `conv_start`=1 for this cycle only → RUN.
- RUN: wait for `conv_done`=1 → SWAP.
- SWAP: toggle `bank_sel`.
  - If `layer_idx`==NUM_LAYERS-1 → FINISH.
  - Else increment `layer_idx` → LAUNCH.
- FINISH: `done`=1 for one cycle → IDLE.
- Bank routing while not IDLE:
  - Bank `bank_sel` is driven by `conv_addr_rd` with wren=0. `conv_data_rd` = that bank's q.
  - Bank `~bank_sel` is driven by `conv_addr_wr`/`conv_data_wr`/`conv_wren`.
- Bank routing in IDLE:
  - Bank `bank_sel` is driven by the host port. `host_q` = that bank's q.
  - The other bank has wren=0.
  - Consequence: after a run the host reads results directly, and the next run consumes them as input. `bank_sel` toggles NUM_LAYERS times per run.
- Host port behaviour while `busy`: `host_wren` is ignored (no RAM write) and `host_q` is driven 0.
- Ignored inputs:
  - `conv_done` outside RUN, including a spurious pulse in LAUNCH.
  - `start` outside IDLE.
- `start` and `host_wren` in the same IDLE cycle: the host write completes, and the run begins next cycle.
- Reset (any state, mid-run included): state=IDLE, `bank_sel`=0, `layer_idx`=0, `conv_start`=0, `done`=0, `busy`=0. All RAM wren are 0 during the reset cycle. RAM contents are undefined after an aborted run.

## Timing
- Reset values: every output is 0 except the pass-through data muxes, which are combinational.
- Accepted `start` at cycle T:
  - `busy`=1 at T+1.
  - `conv_start`=1 at T+1 (LAUNCH).
- `conv_done` at cycle D:
  - SWAP at D+1.
  - The next `conv_start` at D+2, with the updated `bank_sel`/`layer_idx`.
  - For the last layer, `done` at D+2; IDLE and `busy`=0 at D+3.
- Inter-layer overhead: 2 cycles from `conv_done` to the next `conv_start`.
- Address/wren muxing is combinational from the registered `bank_sel`/state. RAM read latency (1 cycle) passes through unchanged.
- `bank_sel` is stable for the whole RUN state, so the q mux needs no delayed select.

## Structure
- Package `cnn_pkg`: `seq_state_t` enum (IDLE, LAUNCH, RUN, SWAP, FINISH) and the shared `BIT_WIDTH` default.
- One sub-module is natural: `bank_mux`, purely combinational two-bank routing keyed on `bank_sel` and `idle`. The FSM and counters stay in `cnn_layer_sequencer`.

## Test plan
- Reset, then host writes 0x0001..0x0010 to addr 0..15 and reads them back → `host_q` matches one cycle after each address; only `ram0_wren` toggles.
- NUM_LAYERS=4, engine model replies `conv_done` 5 cycles after `conv_start` →
  - exactly 4 `conv_start` pulses with `layer_idx` 0,1,2,3 and `bank_sel` 0,1,0,1;
  - `done` 2 cycles after the 4th `conv_done`;
  - final `bank_sel`=0.
- Engine model writes addr+layer into the output bank at each layer → after the run, host reads bank 0 and sees the layer-3 data.
- `start` pulsed during RUN, and `conv_done` injected during LAUNCH → no extra layer or pulse; total `conv_start` count stays 4.
- `rst` asserted in RUN of layer 2 → next cycle IDLE, `bank_sel`=0, `busy`=0; a new run completes normally.
- `host_wren`=1 with `start`=1 in IDLE → word written to `bank_sel` bank. `host_wren` during `busy` → no `ram*_wren` from the host path.
